// File: rtl/key_ascii_pkg.sv
// Shared scan-code / ASCII constants for the keyboard-to-character path.
package key_ascii_pkg;

  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_COMMA  = 8'h41;
  localparam logic [7:0] SC_PERIOD = 8'h49;
  localparam logic [7:0] SC_MINUS  = 8'h4E;

  localparam logic [7:0] ASCII_NONE   = 8'h00;
  localparam logic [7:0] ASCII_BS     = 8'h08;
  localparam logic [7:0] ASCII_SP     = 8'h20;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_PERIOD = 8'h2E;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_UC_A   = 8'h41;
  localparam logic [7:0] ASCII_LC_A   = 8'h61;

endpackage

// File: rtl/key_ascii_fifo_if.sv
// Key-event / character-queue bundle between keyboard controller, FIFO and editor.
interface key_ascii_fifo_if #(parameter int ADDR_W = 4);
  logic [7:0]      KeyData;
  logic            KeyReleased;
  logic            CharRead;
  logic [7:0]      CharOut;
  logic            CharValid;
  logic            Full;
  logic [ADDR_W:0] Count;
  logic            Overflow;

  modport master (
    output KeyData, KeyReleased, CharRead,
    input  CharOut, CharValid, Full, Count, Overflow
  );

  modport slave (
    input  KeyData, KeyReleased, CharRead,
    output CharOut, CharValid, Full, Count, Overflow
  );
endinterface

// File: rtl/key_ascii_fifo_scancode_to_ascii.sv
// Combinational PS/2 set-2 scan code to ASCII lookup; unmapped codes give 8'h00.
// Letter case is selected by KEY_ASCII_UPPERCASE_EN (lowercase when undefined).
module scancode_to_ascii
  import key_ascii_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

`ifdef KEY_ASCII_UPPERCASE_EN
  localparam logic [7:0] LETTER_BASE = ASCII_UC_A;
`else
  localparam logic [7:0] LETTER_BASE = ASCII_LC_A;
`endif

  logic       is_letter, is_digit;
  logic [4:0] letter_idx;
  logic [3:0] digit_idx;

  always_comb begin
    is_letter  = 1'b1;
    letter_idx = 5'd0;
    unique case (code)
      8'h1C: letter_idx = 5'd0;
      8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;
      8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;
      8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;
      8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;
      8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;
      8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;
      8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;
      8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;
      8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;
      8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;
      8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;
      8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;
      8'h1A: letter_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    is_digit  = 1'b1;
    digit_idx = 4'd0;
    unique case (code)
      8'h45: digit_idx = 4'd0;
      8'h16: digit_idx = 4'd1;
      8'h1E: digit_idx = 4'd2;
      8'h26: digit_idx = 4'd3;
      8'h25: digit_idx = 4'd4;
      8'h2E: digit_idx = 4'd5;
      8'h36: digit_idx = 4'd6;
      8'h3D: digit_idx = 4'd7;
      8'h3E: digit_idx = 4'd8;
      8'h46: digit_idx = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    ascii = ASCII_NONE;
    if (is_letter)      ascii = LETTER_BASE + {3'b000, letter_idx};
    else if (is_digit)  ascii = ASCII_ZERO + {4'b0000, digit_idx};
    else begin
      case (code)
        SC_SPACE:  ascii = ASCII_SP;
        SC_BKSP:   ascii = ASCII_BS;
        SC_COMMA:  ascii = ASCII_COMMA;
        SC_PERIOD: ascii = ASCII_PERIOD;
        SC_MINUS:  ascii = ASCII_MINUS;
        default:   ascii = ASCII_NONE;
      endcase
    end
  end

endmodule

// File: rtl/key_ascii_fifo.sv
// Key-release capture, scan-code translation and first-word-fall-through character FIFO.
// Letter case follows KEY_ASCII_UPPERCASE_EN (see scancode_to_ascii).
module key_ascii_fifo
  import key_ascii_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           sys_Clk,
  input  logic           Reset,
  key_ascii_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic                       cap_vld_d, cap_vld_q;
  logic [7:0]                 cap_code_d, cap_code_q;
  logic [ADDR_W-1:0]          wr_ptr_d, wr_ptr_q;
  logic [ADDR_W-1:0]          rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]            count_d, count_q;
  logic                       ovf_d, ovf_q;
  logic [DEPTH-1:0][7:0]      mem_d, mem_q;

  logic [7:0] ascii;
  logic       empty, full, wr_req, push, pop;

  scancode_to_ascii u_lut (
    .code  (cap_code_q),
    .ascii (ascii)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    cap_vld_d  = bus.KeyReleased;
    cap_code_d = bus.KeyReleased ? bus.KeyData : cap_code_q;

    wr_req = cap_vld_q && (ascii != ASCII_NONE);
    pop    = bus.CharRead && !empty;
    // A pop in the same cycle frees the slot, so a write at full still fits.
    push   = wr_req && (!full || pop);
    ovf_d  = ovf_q | (wr_req && full && !pop);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = ascii;
  end

  always_ff @(posedge sys_Clk) begin
    if (Reset) begin
      cap_vld_q  <= 1'b0;
      cap_code_q <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cap_vld_q  <= cap_vld_d;
      cap_code_q <= cap_code_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: a zero count masks stale entries.
  always_ff @(posedge sys_Clk) begin
    mem_q <= mem_d;
  end

  assign bus.CharOut   = empty ? ASCII_NONE : mem_q[rd_ptr_q];
  assign bus.CharValid = !empty;
  assign bus.Full      = full;
  assign bus.Count     = count_q;
  assign bus.Overflow  = ovf_q;

endmodule
